// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits MSB-first, optional even
// parity, stop bit. Good frames update Q with a VALID pulse; bad ones pulse ERR.
module serial_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             D,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             ERR,
    output logic             BUSY
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               perr_q, perr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            q_q     <= '0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            q_q     <= q_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Everything holds on EN=0 cycles; the status pulses fall back to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        q_d     = q_q;
        perr_d  = perr_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (EN) begin
            case (state_q)
                S_IDLE: begin
                    if (D) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                S_DATA: begin
                    sreg_d = {sreg_q[WIDTH-2:0], D};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    // Even parity: the parity bit must equal the XOR of the data bits.
                    perr_d  = D ^ (^sreg_q);
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (!D && !perr_q) begin
                        q_d     = sreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign ERR   = err_q;
    assign BUSY  = (state_q != S_IDLE);

endmodule
